// File: rtl/dff.sv
// dff: parameterizable-width storage register with a synchronous load enable
// and an asynchronous active-high reset. It is the basic state element for
// datapath holding registers such as accumulators and address/data latches.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous reset, active-high; forces q to RESET_VALUE
//   load     in   1      synchronous load enable, active-high
//   data_in  in   WIDTH  value captured on a rising edge when load is high
//   q        out  WIDTH  registered copy of the last loaded value
module dff #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] q
);

    // Reset is tested first, so it overrides load at an edge and clears q
    // between edges. With load low the register holds its current value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= data_in;
        end
    end

endmodule

// File: tb/tb_dff.sv
// tb_dff: self-checking bench for dff. Each scenario task drives stimulus,
// pushes the value q should hold onto a scoreboard queue, and pops and
// compares once the DUT has had the chance to produce it.
module tb_dff;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] q;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] model_q;
    int               n_checks;
    int               n_fail;

    dff #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(16'h0000)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .data_in(data_in),
        .q      (q)
    );

    // Period 20, starting low: rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Absolute time bound so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        // q must be cleared with no clock edge having occurred yet.
        exp_q.push_back(16'h0000);
        #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL reset_no_edge: q=%h expected=%h", q, exp);
        end
        // Still cleared at t=20 after an edge with reset held.
        exp_q.push_back(16'h0000);
        #19;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL reset_held: q=%h expected=%h", q, exp);
        end
        model_q = 16'h0000;
    endtask

    task automatic test_single_load();
        reset   = 1'b0;
        load    = 1'b1;
        data_in = 16'hAAAA;
        exp_q.push_back(16'hAAAA);
        @(posedge clk); #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL single_load: q=%h expected=%h", q, exp);
        end
        exp_q.push_back(16'hAAAA);
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL single_load_stable: q=%h expected=%h", q, exp);
        end
    endtask

    task automatic test_overwrite_hold();
        data_in = 16'h1234;
        load    = 1'b1;
        exp_q.push_back(16'h1234);
        @(posedge clk); #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL overwrite: q=%h expected=%h", q, exp);
        end
        @(negedge clk);
        load    = 1'b0;
        data_in = 16'hFFFF;
        // data_in changes while load is low must be ignored across edges.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(16'h1234);
            @(posedge clk); #1;
            n_checks++;
            exp = exp_q.pop_front();
            if (q !== exp) begin
                n_fail++;
                $display("FAIL hold_%0d: q=%h expected=%h", i, q, exp);
            end
        end
        model_q = 16'h1234;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(16'h0000);
        #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL async_reset_immediate: q=%h expected=%h", q, exp);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(16'h0000);
        @(posedge clk); #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL async_reset_hold: q=%h expected=%h", q, exp);
        end
        model_q = 16'h0000;
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        reset   = 1'b1;
        load    = 1'b1;
        data_in = 16'h5555;
        exp_q.push_back(16'h0000);
        @(posedge clk); #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL reset_priority: q=%h expected=%h", q, exp);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(16'h5555);
        @(posedge clk); #1;
        n_checks++;
        exp = exp_q.pop_front();
        if (q !== exp) begin
            n_fail++;
            $display("FAIL load_after_reset: q=%h expected=%h", q, exp);
        end
        model_q = 16'h5555;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pattern[3];
        pattern[0] = 16'h0001;
        pattern[1] = 16'h8000;
        pattern[2] = 16'hFFFF;
        @(negedge clk);
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = pattern[i];
            exp_q.push_back(pattern[i]);
            @(posedge clk); #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_%0d: scoreboard empty, q=%h", i, q);
            end else begin
                exp = exp_q.pop_front();
                if (q !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: q=%h expected=%h", i, q, exp);
                end
            end
        end
        load    = 1'b0;
        model_q = 16'hFFFF;
    endtask

    task automatic test_random();
        // Mixed loads and holds against a one-register reference model.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            load    = 1'($urandom_range(0, 1));
            data_in = WIDTH'($urandom);
            if (load) model_q = data_in;
            exp_q.push_back(model_q);
            @(posedge clk); #1;
            n_checks++;
            exp = exp_q.pop_front();
            if (q !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: load=%b q=%h expected=%h", i, load, q, exp);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        load     = 1'b0;
        data_in  = '0;
        model_q  = '0;

        test_reset();
        test_single_load();
        test_overwrite_hold();
        test_async_reset();
        test_reset_priority();
        test_back_to_back();
        test_random();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
